// File: rtl/byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : byte_serializer
// Description : Parallel-in / serial-out stage with a valid/ready input.
//               Emits each accepted word LSB-first, one bit per clock, and
//               inserts an optional number of idle cycles after every word.
//               A one-cycle byte_done strobe marks the last bit of a word.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_serializer #(
    parameter int W   = 8,
    parameter int GAP = 0
) (
    input  logic         clock,
    input  logic         r,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         so,
    output logic         so_valid,
    output logic         byte_done
);

    // Bit counter only needs to reach W-1; gap counter must hold GAP.
    // GAP==0 never uses the gap counter, but it keeps a legal 1-bit width.
    localparam int CW = $clog2(W);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
    localparam logic [GW-1:0] c_GAP_LOAD = GW'(GAP);
    localparam logic [GW-1:0] c_GAP_ONE  = GW'(1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_GAP   = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [W-1:0]  r_sr;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gap;

    logic w_last;
    logic w_ready;
    logic w_accept;

    // Final bit of the word in flight is on the output this cycle.
    assign w_last   = (r_state == c_S_SHIFT) && (r_cnt == c_CNT_LAST);
    // Ready depends only on registered state and reset, never on din/din_valid.
    assign w_ready  = !r && ((r_state == c_S_IDLE) || ((GAP == 0) && w_last));
    assign w_accept = din_valid && w_ready;

    // State register: reset returns to idle, otherwise follow next-state logic.
    always_ff @(posedge clock) begin
        if (r) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: word start, end of word (gap or stream) and gap end.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                if (w_last) begin
                    if (GAP > 0) begin
                        w_state_nxt = c_S_GAP;
                    end else if (w_accept) begin
                        w_state_nxt = c_S_SHIFT;
                    end else begin
                        w_state_nxt = c_S_IDLE;
                    end
                end
            end
            c_S_GAP: begin
                if (r_gap <= c_GAP_ONE) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Datapath: load on acceptance, shift right with zero fill while shifting,
    // and run the gap counter down between words.
    always_ff @(posedge clock) begin
        if (r) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_gap <= '0;
        end else begin
            if (w_accept) begin
                r_sr  <= din;
                r_cnt <= '0;
            end else if (r_state == c_S_SHIFT) begin
                r_sr <= r_sr >> 1;
                // Hold at W-1 so the counter never wraps for power-of-two W.
                if (!w_last) begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end

            if (w_last && (GAP > 0)) begin
                r_gap <= c_GAP_LOAD;
            end else if ((r_state == c_S_GAP) && (r_gap != '0)) begin
                r_gap <= r_gap - c_GAP_ONE;
            end
        end
    end

    // Output decode from registered state only.
    always_comb begin
        so        = 1'b0;
        so_valid  = 1'b0;
        byte_done = 1'b0;
        din_ready = w_ready;
        if (r_state == c_S_SHIFT) begin
            so        = r_sr[0];
            so_valid  = 1'b1;
            byte_done = w_last;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_serializer
// Description : Drives two serializers (GAP=0 and GAP=2, W=8) from a shared
//               source and compares every output, every cycle, against a
//               word-level timing model plus an attached downstream register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_serializer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       r         = 1'b1;
    logic       din_valid = 1'b0;
    logic [7:0] din       = 8'h00;

    logic [1:0] w_rdy;
    logic [1:0] w_so;
    logic [1:0] w_sv;
    logic [1:0] w_bd;

    byte_serializer #(.W(8), .GAP(0)) u_dut_g0 (
        .clock     (clock),
        .r         (r),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (w_rdy[0]),
        .so        (w_so[0]),
        .so_valid  (w_sv[0]),
        .byte_done (w_bd[0])
    );

    byte_serializer #(.W(8), .GAP(2)) u_dut_g2 (
        .clock     (clock),
        .r         (r),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (w_rdy[1]),
        .so        (w_so[1]),
        .so_valid  (w_sv[1]),
        .byte_done (w_bd[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model per instance: the word in flight, which of its bits is
    // on the wire this cycle (-1 when none), and idle cycles left before the
    // source may be served again.
    int         gap_of [2] = '{0, 2};
    int         pos    [2];
    int         hold   [2];
    logic [7:0] cur    [2];
    logic [7:0] down   [2];
    logic [7:0] done_byte [2];
    logic       chk_down  [2];
    logic       armed = 1'b0;

    task automatic check(input string tag, input int m, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, m, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs mid-cycle, compare outputs, then advance
    // the model and the downstream shift register across the rising edge.
    task automatic cycle(input logic rr, input logic vv, input logic [7:0] dd);
        logic [1:0] e_rdy;
        logic [1:0] e_so;
        logic [1:0] e_sv;
        logic [1:0] e_bd;
        logic [1:0] so_seen;
        @(negedge clock);
        r         = rr;
        din_valid = vv;
        din       = dd;
        #1;
        for (int m = 0; m < 2; m++) begin
            e_rdy[m] = !rr && (((pos[m] < 0) && (hold[m] == 0)) || ((gap_of[m] == 0) && (pos[m] == 7)));
            e_sv[m]  = (pos[m] >= 0);
            e_so[m]  = (pos[m] >= 0) ? cur[m][pos[m]] : 1'b0;
            e_bd[m]  = (pos[m] == 7);
            if (armed) begin
                check("din_ready", m, {7'd0, w_rdy[m]}, {7'd0, e_rdy[m]});
                check("so",        m, {7'd0, w_so[m]},  {7'd0, e_so[m]});
                check("so_valid",  m, {7'd0, w_sv[m]},  {7'd0, e_sv[m]});
                check("byte_done", m, {7'd0, w_bd[m]},  {7'd0, e_bd[m]});
                if (chk_down[m]) begin
                    check("downstream_w", m, down[m], done_byte[m]);
                end
            end
            so_seen[m] = w_so[m];
        end
        @(posedge clock);
        for (int m = 0; m < 2; m++) begin
            down[m]      = {so_seen[m], down[m][7:1]};
            chk_down[m]  = !rr && e_bd[m];
            done_byte[m] = cur[m];
            if (rr) begin
                pos[m]  = -1;
                hold[m] = 0;
            end else if (vv && e_rdy[m]) begin
                cur[m] = dd;
                pos[m] = 0;
            end else if (pos[m] == 7) begin
                pos[m]  = -1;
                hold[m] = gap_of[m];
            end else if (pos[m] >= 0) begin
                pos[m] = pos[m] + 1;
            end else if (hold[m] > 0) begin
                hold[m] = hold[m] - 1;
            end
        end
        armed = armed || rr;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            pos[m]       = -1;
            hold[m]      = 0;
            cur[m]       = 8'h00;
            down[m]      = 8'h00;
            done_byte[m] = 8'h00;
            chk_down[m]  = 1'b0;
        end

        // Reset held with a valid source offering 0xFF.
        repeat (3) cycle(1'b1, 1'b1, 8'hFF);

        // Single word 0xA5.
        cycle(1'b0, 1'b1, 8'hA5);
        repeat (12) cycle(1'b0, 1'b0, 8'h00);

        // Back-to-back 0x3C then 0xC3 with valid held high.
        cycle(1'b0, 1'b1, 8'h3C);
        repeat (8) cycle(1'b0, 1'b1, 8'hC3);
        repeat (12) cycle(1'b0, 1'b0, 8'h00);

        // Continuous source: exercises streaming and gap insertion.
        repeat (25) cycle(1'b0, 1'b1, 8'($urandom));
        repeat (12) cycle(1'b0, 1'b0, 8'h00);

        // Reset during the 4th bit of 0xFF, then 0x01.
        cycle(1'b0, 1'b1, 8'hFF);
        repeat (3) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h01);
        repeat (12) cycle(1'b0, 1'b0, 8'h00);

        // Busy-time noise: valid toggles and data changes every cycle,
        // with occasional resets.
        repeat (600) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
        end
        repeat (15) cycle(1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
